miner_nonce_dispatch: RTL and testbench

//  Multi-core successor to the single-core miner_top. Accepts a mining job (header, target, nonce range)
//  and issues nonces round-robin to NUM_CORES external hash cores. Checks each returned digest against the

---
 rtl/miner_pkg.sv | 18 +
 rtl/miner_found_fifo.sv | 49 ++++
 rtl/miner_nonce_dispatch.sv | 177 +++++++++++++++++
 tb/tb_miner_nonce_dispatch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the multi-core miner: default datapath widths,
// the nonce padding constant and the dispatcher state encoding.
package miner_pkg;

    localparam int DEF_NONCE_W  = 32;
    localparam int DEF_HEADER_W = 608;
    localparam int DEF_TARGET_W = 256;

    // Low bits appended to a winning nonce: the SHA padding marker and zeros.
    localparam logic [11:0] PAD_BITS = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/miner_found_fifo.sv
// Synchronous first-word-fall-through FIFO holding winning nonces.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module miner_found_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/miner_nonce_dispatch.sv
// Nonce dispatcher: issues a job's nonce range round-robin to external hash
// cores, checks returned digests against the target and queues the winners.
module miner_nonce_dispatch
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NONCE_W    = DEF_NONCE_W,
    parameter int HEADER_W   = DEF_HEADER_W,
    parameter int TARGET_W   = DEF_TARGET_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PAD_W      = NONCE_W + 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [HEADER_W-1:0]  job_header,
    input  logic [TARGET_W-1:0]  job_target,
    input  logic [NONCE_W-1:0]   job_nonce_lo,
    input  logic [NONCE_W-1:0]   job_nonce_hi,
    input  logic                 job_stop_first,
    input  logic                 abort,
    output logic [HEADER_W-1:0]  hdr_out,
    input  logic [NUM_CORES-1:0] core_ready,
    output logic [NUM_CORES-1:0] core_issue,
    output logic [NONCE_W-1:0]   core_nonce,
    input  logic                 res_valid,
    input  logic [NONCE_W-1:0]   res_nonce,
    input  logic [TARGET_W-1:0]  res_digest,
    output logic                 found_valid,
    input  logic                 found_ready,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [PAD_W-1:0]     found_padded,
    output logic                 job_done,
    output logic                 overflow,
    output logic                 busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(NUM_CORES * 4) + 1;

    state_t               state;
    state_t               state_nxt;
    logic [HEADER_W-1:0]  header_q;
    logic [TARGET_W-1:0]  target_q;
    logic [NONCE_W-1:0]   hi_q;
    logic [NONCE_W-1:0]   next_nonce;
    logic [NONCE_W-1:0]   hit_nonce_q;
    logic                 stop_first_q;
    logic                 hit_q;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic                 grant_any;
    logic                 grant;
    logic                 res_live;
    logic                 hit_now;
    logic                 last_issue;
    logic [CNT_W-1:0]     outstanding;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Round-robin search begins one past the most recently granted core.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_CORES);
            if (!grant_any && core_ready[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Results arriving in IDLE are leftovers from an aborted job and are ignored.
    assign res_live   = res_valid && (state != IDLE) && !abort;
    assign hit_now    = res_live && (res_digest <= target_q);
    assign grant      = (state == RUN) && !abort && grant_any && !(stop_first_q && hit_now);
    assign last_issue = grant && (next_nonce == hi_q);

    assign core_issue = grant ? (NUM_CORES'(1) << grant_idx) : '0;
    assign core_nonce = grant ? next_nonce : '0;
    assign hdr_out    = header_q;
    assign job_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        job_done  = 1'b0;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (job_valid) state_nxt = (job_nonce_lo > job_nonce_hi) ? DRAIN : RUN;
                RUN:   if (last_issue || (stop_first_q && hit_now)) state_nxt = DRAIN;
                DRAIN: if (outstanding == '0) begin
                           job_done  = 1'b1;
                           state_nxt = IDLE;
                       end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The last nonce is never incremented, so hi = all-ones cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            header_q     <= '0;
            target_q     <= '0;
            hi_q         <= '0;
            next_nonce   <= '0;
            stop_first_q <= 1'b0;
            last_grant   <= IDX_W'(NUM_CORES - 1);
            hit_q        <= 1'b0;
            hit_nonce_q  <= '0;
        end else begin
            hit_q       <= hit_now;
            hit_nonce_q <= res_nonce;
            if (state == IDLE && job_valid) begin
                header_q     <= job_header;
                target_q     <= job_target;
                hi_q         <= job_nonce_hi;
                next_nonce   <= job_nonce_lo;
                stop_first_q <= job_stop_first;
                last_grant   <= IDX_W'(NUM_CORES - 1);
            end else if (grant) begin
                last_grant <= grant_idx;
                if (!last_issue) next_nonce <= next_nonce + NONCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (abort) begin
            outstanding <= '0;
        end else if (grant && !res_live) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!grant && res_live && outstanding != '0) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    assign pop = found_ready && found_valid;

    always_ff @(posedge clk) begin
        if (!rst_n)                              overflow <= 1'b0;
        else if (hit_q && fifo_full && !pop)     overflow <= 1'b1;
    end

    miner_found_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_found_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (hit_q),
        .push_data (hit_nonce_q),
        .pop       (pop),
        .head_data (found_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign found_valid  = !fifo_empty;
    assign found_padded = found_valid ? PAD_W'({found_nonce, PAD_BITS}) : '0;

endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// Directed, table-driven bench for miner_nonce_dispatch: one row per clock
// cycle holding the inputs and the outputs expected during that cycle.
module tb_miner_nonce_dispatch;

    localparam logic [255:0] TGT  = 256'h100;
    localparam logic [607:0] HDR1 = {19{32'hA5A5_0001}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [607:0]  job_header;
    logic [255:0]  job_target;
    logic [31:0]   job_nonce_lo;
    logic [31:0]   job_nonce_hi;
    logic          job_stop_first;
    logic          abort;
    logic [607:0]  hdr_out;
    logic [3:0]    core_ready;
    logic [3:0]    core_issue;
    logic [31:0]   core_nonce;
    logic          res_valid;
    logic [31:0]   res_nonce;
    logic [255:0]  res_digest;
    logic          found_valid;
    logic          found_ready;
    logic [31:0]   found_nonce;
    logic [43:0]   found_padded;
    logic          job_done;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        jv;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        stop;
        logic [3:0]  ready;
        logic        rv;
        logic [31:0] rn;
        logic        rhit;
        logic        fr;
        logic        ab;
        logic [3:0]  e_issue;
        logic [31:0] e_nonce;
        logic        e_jr;
        logic        e_busy;
        logic        e_done;
        logic        e_fv;
        logic [31:0] e_fn;
    } vec_t;

    vec_t vecs[$];

    miner_nonce_dispatch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_header     (job_header),
        .job_target     (job_target),
        .job_nonce_lo   (job_nonce_lo),
        .job_nonce_hi   (job_nonce_hi),
        .job_stop_first (job_stop_first),
        .abort          (abort),
        .hdr_out        (hdr_out),
        .core_ready     (core_ready),
        .core_issue     (core_issue),
        .core_nonce     (core_nonce),
        .res_valid      (res_valid),
        .res_nonce      (res_nonce),
        .res_digest     (res_digest),
        .found_valid    (found_valid),
        .found_ready    (found_ready),
        .found_nonce    (found_nonce),
        .found_padded   (found_padded),
        .job_done       (job_done),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic jv, input logic [31:0] lo, input logic [31:0] hi,
                                input logic stop, input logic [3:0] ready, input logic rv,
                                input logic [31:0] rn, input logic rhit, input logic fr,
                                input logic ab, input logic [3:0] e_issue, input logic [31:0] e_nonce,
                                input logic e_jr, input logic e_busy, input logic e_done,
                                input logic e_fv, input logic [31:0] e_fn);
        vec_t v;
        v.jv = jv; v.lo = lo; v.hi = hi; v.stop = stop; v.ready = ready;
        v.rv = rv; v.rn = rn; v.rhit = rhit; v.fr = fr; v.ab = ab;
        v.e_issue = e_issue; v.e_nonce = e_nonce; v.e_jr = e_jr; v.e_busy = e_busy;
        v.e_done = e_done; v.e_fv = e_fv; v.e_fn = e_fn;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        job_valid      = v.jv;
        job_nonce_lo   = v.lo;
        job_nonce_hi   = v.hi;
        job_stop_first = v.stop;
        core_ready     = v.ready;
        res_valid      = v.rv;
        res_nonce      = v.rn;
        res_digest     = v.rhit ? TGT : TGT + 256'd1;
        found_ready    = v.fr;
        abort          = v.ab;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkValue({tag, " core_issue"}, 64'(core_issue), 64'(v.e_issue));
        checkValue({tag, " core_nonce"}, 64'(core_nonce), 64'(v.e_issue != 4'h0 ? v.e_nonce : 32'h0));
        checkValue({tag, " job_ready"},  64'(job_ready),  64'(v.e_jr));
        checkValue({tag, " busy"},       64'(busy),       64'(v.e_busy));
        checkValue({tag, " job_done"},   64'(job_done),   64'(v.e_done));
        checkValue({tag, " found_valid"}, 64'(found_valid), 64'(v.e_fv));
        if (v.e_fv) checkValue({tag, " found_nonce"}, 64'(found_nonce), 64'(v.e_fn));
    endtask

    // Drive a row at the falling edge and check once inputs have settled.
    task automatic runVec(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(v, tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        job_header = HDR1;
        job_target = TGT;
        applyStimulus(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "reset");
        checkValue("reset overflow", 64'(overflow), 64'h0);
        checkValue("reset hdr_out zero", 64'(hdr_out == '0), 64'h1);
        checkValue("reset found_padded", 64'(found_padded), 64'h0);
        rst_n = 1'b1;

        // Job 1: nonces 0..7, all misses; results return one cycle after issue.
        vecs.push_back(mk(1, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 7, 0, 4'hF, (k >= 2), 32'(k - 2), 0, 0, 0,
                              4'(1 << ((k - 1) % 4)), 32'(k - 1), 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 1, 7, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
        // Job 2: same range, digest equals target for nonce 5 (result row 7).
        vecs.push_back(mk(1, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 7, 0, 4'hF, (k >= 2), 32'(k - 2), (k == 7), 0, 0,
                              4'(1 << ((k - 1) % 4)), 32'(k - 1), 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 1, 7, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1, 5));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 1, 5));
        vecs.push_back(mk(0, 0, 7, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 5));

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));
        checkValue("found_padded nonce5", 64'(found_padded), 64'h00000005800);
        checkValue("hdr_out latched", 64'(hdr_out == HDR1), 64'h1);
        checkValue("overflow after one hit", 64'(overflow), 64'h0);
        runVec(mk(0, 0, 7, 0, 4'h0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0, 0, 1, 5), "pop5");
        runVec(mk(0, 0, 7, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "pop5 empty");

        // stop_first: three issued, hit on nonce 2 halts issuing even with cores ready.
        runVec(mk(1, 0, 7, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "stop c0");
        runVec(mk(0, 0, 7, 1, 4'hF, 0, 0, 0, 0, 0, 4'h1, 0, 0, 1, 0, 0, 0), "stop c1");
        runVec(mk(0, 0, 7, 1, 4'hF, 0, 0, 0, 0, 0, 4'h2, 1, 0, 1, 0, 0, 0), "stop c2");
        runVec(mk(0, 0, 7, 1, 4'hF, 0, 0, 0, 0, 0, 4'h4, 2, 0, 1, 0, 0, 0), "stop c3");
        runVec(mk(0, 0, 7, 1, 4'hF, 1, 2, 1, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0), "stop c4");
        runVec(mk(0, 0, 7, 1, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0), "stop c5");
        runVec(mk(0, 0, 7, 1, 4'hF, 1, 1, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1, 2), "stop c6");
        runVec(mk(0, 0, 7, 1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 1, 2), "stop c7");
        runVec(mk(0, 0, 7, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 2), "stop c8");
        runVec(mk(0, 0, 7, 1, 4'h0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0, 0, 1, 2), "stop pop");
        runVec(mk(0, 0, 7, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "stop empty");

        // Six hits against a four-entry FIFO with nobody popping.
        runVec(mk(1, 100, 105, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "ovf c0");
        for (int k = 1; k <= 6; k++)
            runVec(mk(0, 100, 105, 0, 4'hF, (k >= 2), 32'(98 + k), 1, 0, 0,
                      4'(1 << ((k - 1) % 4)), 32'(99 + k), 0, 1, 0, (k >= 4), 100),
                   $sformatf("ovf c%0d", k));
        runVec(mk(0, 100, 105, 0, 4'hF, 1, 105, 1, 0, 0, 4'h0, 0, 0, 1, 0, 1, 100), "ovf c7");
        checkValue("overflow before drop", 64'(overflow), 64'h0);
        runVec(mk(0, 100, 105, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 1, 100), "ovf c8");
        checkValue("overflow after drop", 64'(overflow), 64'h1);
        runVec(mk(0, 100, 105, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 100), "ovf c9");
        for (int j = 0; j < 4; j++)
            runVec(mk(0, 100, 105, 0, 4'h0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0, 0, 1, 32'(100 + j)),
                   $sformatf("ovf pop%0d", j));
        runVec(mk(0, 100, 105, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "ovf empty");
        checkValue("overflow sticky", 64'(overflow), 64'h1);

        // Top of the nonce space: exactly one issue, no wrap to zero.
        runVec(mk(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "max c0");
        runVec(mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 32'hFFFFFFFF, 0, 1, 0, 0, 0), "max c1");
        runVec(mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'hF, 1, 32'hFFFFFFFF, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0), "max c2");
        runVec(mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0), "max c3");
        runVec(mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "max c4");

        // Abort mid-run, stale hit while idle, new job accepted right away.
        runVec(mk(1, 0, 100, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "abort c0");
        runVec(mk(0, 0, 100, 0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 0, 0, 1, 0, 0, 0), "abort c1");
        runVec(mk(0, 0, 100, 0, 4'hF, 0, 0, 0, 0, 0, 4'h2, 1, 0, 1, 0, 0, 0), "abort c2");
        runVec(mk(0, 0, 100, 0, 4'hF, 0, 0, 0, 0, 1, 4'h0, 0, 0, 1, 0, 0, 0), "abort c3");
        runVec(mk(1, 200, 200, 0, 4'hF, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "abort c4");
        runVec(mk(0, 200, 200, 0, 4'hF, 0, 0, 0, 0, 0, 4'h1, 200, 0, 1, 0, 0, 0), "abort c5");
        runVec(mk(0, 200, 200, 0, 4'hF, 1, 200, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0), "abort c6");
        runVec(mk(0, 200, 200, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0), "abort c7");
        runVec(mk(0, 200, 200, 0, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0), "abort c8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
